// File: rtl/gate_tree_pkg.sv
// Shared types and constants for the pipelined gate-reduction tree.
package gate_tree_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  localparam int CNT_W = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/gate_tree_stage.sv
// One tree level: pairwise per-lane combine of adjacent operands, registered
// together with its valid bit and opcode; everything holds while stalled.
module gate_tree_stage
  import gate_tree_pkg::*;
#(
  parameter int N_IN_S = 2,
  parameter int LANES  = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall_i,
  input  logic                           flush_i,
  input  logic                           vld_i,
  input  op_e                            op_i,
  input  logic                           inv_i,
  input  logic [N_IN_S*LANES-1:0]        data_i,
  output logic                           vld_o,
  output op_e                            op_o,
  output logic [(N_IN_S/2)*LANES-1:0]    data_o
);

  localparam int N_OUT = N_IN_S / 2;

  logic                   vld_q;
  op_e                    op_q;
  logic [N_OUT*LANES-1:0] data_q;
  logic [N_OUT*LANES-1:0] data_d;

  // NAND shares the AND combine; inversion is requested by the top at the last level only
  always_comb begin
    data_d = '0;
    for (int j = 0; j < N_OUT; j++) begin
      case (op_i)
        OP_OR:   data_d[j*LANES +: LANES] = data_i[2*j*LANES +: LANES] | data_i[(2*j+1)*LANES +: LANES];
        OP_XOR:  data_d[j*LANES +: LANES] = data_i[2*j*LANES +: LANES] ^ data_i[(2*j+1)*LANES +: LANES];
        default: data_d[j*LANES +: LANES] = data_i[2*j*LANES +: LANES] & data_i[(2*j+1)*LANES +: LANES];
      endcase
    end
    data_d = data_d ^ {(N_OUT*LANES){inv_i}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      op_q   <= OP_AND;
      data_q <= '0;
    end else begin
      if (flush_i)       vld_q <= 1'b0;
      else if (!stall_i) vld_q <= vld_i;
      if (!stall_i) begin
        op_q   <= op_i;
        data_q <= data_d;
      end
    end
  end

  assign vld_o  = vld_q;
  assign op_o   = op_q;
  assign data_o = data_q;

endmodule

// File: rtl/gate_tree_pipe.sv
// Pipelined AND/OR/XOR/NAND reduction tree with valid/ready and flush.
// Optional GATE_TREE_CNT_EN adds a saturating result counter on result_cnt.
module gate_tree_pipe
  import gate_tree_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int LANES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*LANES-1:0] in_data,
  input  logic [1:0]            in_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      out_data,
  output logic [1:0]            out_op
`ifdef GATE_TREE_CNT_EN
  ,
  output logic [CNT_W-1:0]      result_cnt
`endif
);

  localparam int LVL    = clog2(N_IN);
  localparam int TREE_W = (2*N_IN - 1) * LANES;

  // All levels packed back to back: level s starts at operand offset 2*N_IN - (2*N_IN >> s)
  logic [TREE_W-1:0] tree_data;
  logic [LVL:0]      tree_vld;
  op_e               tree_op [0:LVL];
  logic              stall;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  assign tree_data[N_IN*LANES-1:0] = in_data;
  assign tree_vld[0]               = in_valid;
  assign tree_op[0]                = op_e'(in_op);

  genvar s;
  generate
    for (s = 1; s <= LVL; s++) begin : g_lvl
      localparam int W_IN    = N_IN >> (s - 1);
      localparam int OFF_IN  = 2*N_IN - 2*W_IN;
      localparam int OFF_OUT = 2*N_IN - W_IN;
      logic inv;
      if (s == LVL) begin : g_nand
        assign inv = (tree_op[s-1] == OP_NAND);
      end else begin : g_pass
        assign inv = 1'b0;
      end
      gate_tree_stage #(
        .N_IN_S (W_IN),
        .LANES  (LANES)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall_i (stall),
        .flush_i (flush),
        .vld_i   (tree_vld[s-1]),
        .op_i    (tree_op[s-1]),
        .inv_i   (inv),
        .data_i  (tree_data[OFF_IN*LANES +: W_IN*LANES]),
        .vld_o   (tree_vld[s]),
        .op_o    (tree_op[s]),
        .data_o  (tree_data[OFF_OUT*LANES +: (W_IN/2)*LANES])
      );
    end
  endgenerate

  assign out_valid = tree_vld[LVL];
  assign out_data  = tree_data[(2*N_IN-2)*LANES +: LANES];
  assign out_op    = tree_op[LVL];

`ifdef GATE_TREE_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (flush)                                        cnt_d = '0;
    else if (out_valid && out_ready && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign result_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_gate_tree_pipe.sv
// Directed self-checking bench for gate_tree_pipe (N_IN=4/LANES=1 and N_IN=16/LANES=8).
module tb_gate_tree_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, flush, in_valid, out_ready;
  logic [3:0] in_data;
  logic [1:0] in_op;
  logic       in_ready, out_valid;
  logic [0:0] out_data;
  logic [1:0] out_op;

  logic         b_flush, b_in_valid, b_out_ready;
  logic [127:0] b_in_data;
  logic [1:0]   b_in_op;
  logic         b_in_ready, b_out_valid;
  logic [7:0]   b_out_data;
  logic [1:0]   b_out_op;

`ifdef GATE_TREE_CNT_EN
  logic [15:0] cnt, b_cnt;
`endif

  gate_tree_pipe #(.N_IN(4), .LANES(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_op(out_op)
`ifdef GATE_TREE_CNT_EN
    , .result_cnt(cnt)
`endif
  );

  gate_tree_pipe #(.N_IN(16), .LANES(8)) dut_big (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_op(b_in_op), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_op(b_out_op)
`ifdef GATE_TREE_CNT_EN
    , .result_cnt(b_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  logic [3:0] vd [16];
  logic [1:0] vo [16];
  logic       ve [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Feeds vd/vo back to back with out_ready=1 and checks each result one edge later than stage 1.
  task automatic run_b2b(input int n, input string tag);
    in_valid = 1'b1;
    in_data  = vd[0];
    in_op    = vo[0];
    for (int i = 0; i <= n; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        check({tag, "_lat"}, 32'(out_valid), 32'd0);
      end else begin
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_dat"}, 32'(out_data), 32'(ve[i-1]));
        check({tag, "_op"},  32'(out_op),   32'(vo[i-1]));
      end
      if (i + 1 < n) begin
        in_data = vd[i+1];
        in_op   = vo[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    check({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_op = '0; out_ready = 1'b1;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_op = '0; b_out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_vld",   32'(out_valid), 32'd0);
    check("rst_dat",   32'(out_data),  32'd0);
    check("rst_op",    32'(out_op),    32'd0);
    check("rst_ready", 32'(in_ready),  32'd1);
`ifdef GATE_TREE_CNT_EN
    check("rst_cnt", 32'(cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // exhaustive AND sweep
    for (int k = 0; k < 16; k++) begin
      vd[k] = 4'(k);
      vo[k] = 2'b00;
      ve[k] = (k == 15);
    end
    run_b2b(16, "sweep");
`ifdef GATE_TREE_CNT_EN
    check("sweep_cnt", 32'(cnt), 32'd16);
`endif

    // mixed opcodes back to back
    vd[0] = 4'b1010; vo[0] = 2'b00; ve[0] = 1'b0;
    vd[1] = 4'b1010; vo[1] = 2'b01; ve[1] = 1'b1;
    vd[2] = 4'b1010; vo[2] = 2'b10; ve[2] = 1'b0;
    vd[3] = 4'b1010; vo[3] = 2'b11; ve[3] = 1'b1;
    vd[4] = 4'b1111; vo[4] = 2'b11; ve[4] = 1'b0;
    vd[5] = 4'b0111; vo[5] = 2'b11; ve[5] = 1'b1;
    vd[6] = 4'b0110; vo[6] = 2'b10; ve[6] = 1'b0;
    vd[7] = 4'b0100; vo[7] = 2'b01; ve[7] = 1'b1;
    run_b2b(8, "mixed");

    // backpressure with a full pipeline
    out_ready = 1'b1; in_valid = 1'b1; in_data = 4'b1010; in_op = 2'b00;
    @(posedge clk); #1;
    in_op = 2'b01;
    @(posedge clk); #1;
    check("bp_pre_op", 32'(out_op), 32'd0);
    out_ready = 1'b0;
    in_op     = 2'b10;
    #1;
    for (int c = 0; c < 5; c++) begin
      check("bp_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check("bp_vld", 32'(out_valid), 32'd1);
      check("bp_op",  32'(out_op),    32'd0);
      check("bp_dat", 32'(out_data),  32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_r1_vld", 32'(out_valid), 32'd1);
    check("bp_r1_op",  32'(out_op),    32'd1);
    check("bp_r1_dat", 32'(out_data),  32'd1);
    @(posedge clk); #1;
    check("bp_r2_vld", 32'(out_valid), 32'd1);
    check("bp_r2_op",  32'(out_op),    32'd2);
    check("bp_r2_dat", 32'(out_data),  32'd0);
    @(posedge clk); #1;
    check("bp_empty", 32'(out_valid), 32'd0);

    // flush with two in flight plus a new input
    in_valid = 1'b1; in_data = 4'b1010; in_op = 2'b01;
    @(posedge clk); #1;
    in_op = 2'b11;
    @(posedge clk); #1;
    check("fl_pre_vld", 32'(out_valid), 32'd1);
    flush = 1'b1;
    in_op = 2'b10;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_vld", 32'(out_valid), 32'd0);
`ifdef GATE_TREE_CNT_EN
    check("fl_cnt", 32'(cnt), 32'd0);
`endif
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("fl_idle", 32'(out_valid), 32'd0);
    end

    // asynchronous reset mid-stream
    in_valid = 1'b1; in_data = 4'b1111; in_op = 2'b01;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ar_pre_vld", 32'(out_valid), 32'd1);
    check("ar_pre_dat", 32'(out_data),  32'd1);
    check("ar_pre_op",  32'(out_op),    32'd1);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("ar_vld",   32'(out_valid), 32'd0);
    check("ar_dat",   32'(out_data),  32'd0);
    check("ar_op",    32'(out_op),    32'd0);
    check("ar_ready", 32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    vd[0] = 4'b1111; vo[0] = 2'b10; ve[0] = 1'b0;
    vd[1] = 4'b0111; vo[1] = 2'b11; ve[1] = 1'b1;
    run_b2b(2, "rst");

    // N_IN=16, LANES=8 with operands 1..16
    for (int k = 0; k < 16; k++) b_in_data[k*8 +: 8] = 8'(k + 1);
    b_in_valid = 1'b1; b_in_op = 2'b10;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("big_x_lat", 32'(b_out_valid), 32'd0);
      @(posedge clk); #1;
    end
    check("big_x_vld", 32'(b_out_valid), 32'd1);
    check("big_x_dat", 32'(b_out_data),  32'h10);
    check("big_x_op",  32'(b_out_op),    32'd2);

    b_in_valid = 1'b1; b_in_op = 2'b01;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("big_o_lat", 32'(b_out_valid), 32'd0);
      @(posedge clk); #1;
    end
    check("big_o_vld", 32'(b_out_valid), 32'd1);
    check("big_o_dat", 32'(b_out_data),  32'h1F);
    check("big_o_op",  32'(b_out_op),    32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/gate_tree_pipe.md
# gate_tree_pipe

- Parametrised, pipelined successor to the team's fixed four-input delayed AND network.
- Reduces N_IN operands, each LANES bits wide, through a balanced binary tree with one register stage per tree level.
- The operation is selectable per transaction: AND, OR, XOR or NAND.
- Has a valid/ready handshake with a global stall and a synchronous flush; it sits between a stimulus/operand source and any registered consumer.

## Interface
Parameters:
- N_IN, 4, operand count; power of two, 2..64
- LANES, 1, bits per operand; 1..32
- LVL (localparam), log2(N_IN), tree depth = pipeline latency

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous; drops all in-flight transactions
- in_valid  input  1  operand set present
- in_ready  output  1  block can accept this cycle
- in_data  input  N_IN*LANES  operand k at bits [k*LANES +: LANES]
- in_op  input  2  00 AND, 01 OR, 10 XOR, 11 NAND; sampled with in_data
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts
- out_data  output  LANES  reduced result
- out_op  output  2  opcode that produced out_data
- result_cnt  output  16  only with GATE_TREE_CNT_EN; see Configuration

## Operation
- Stage s (1..LVL) holds N_IN>>s lane-vectors, plus a valid bit and an opcode.
- Each stage combines adjacent pairs (2j, 2j+1) of the previous level, bitwise per lane.
- Combining function per stage: AND for ops 00 and 11, OR for 01, XOR for 10.
- NAND inversion is applied only at the final stage register: out_data = ~AND-reduce.
- Opcode travels with its data; different ops may be in flight together, with no cross-contamination.
- Stall is global: stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stalled, every stage register holds its value.
- Accept: in_valid && in_ready. Stage-1 valid loads in_valid when not stalled, so bubbles propagate.
- Bubbles are not collapsed. Fixed latency is guaranteed in preference to throughput.
- Flush:
  - Next edge clears all stage valids, including out_valid.
  - Data registers are not cleared.
  - Flush has priority over accept, so an input presented in the flush cycle is dropped.
- Reset: all valids 0, all data 0, all opcodes 00 ⇒ out_valid=0, out_data=0, out_op=00, in_ready=1.
- Reset is legal mid-transaction; in-flight data is lost and no output is produced.

## Timing
- Latency: a set accepted at edge t appears with out_valid=1 after edge t+LVL-1, i.e. visible for the cycle following edge t+LVL-1. With N_IN=4 it is visible two cycles after acceptance.
- Throughput: 1 transaction/cycle with out_ready held high.
- in_ready is purely combinational from out_valid and out_ready; there is no path from in_valid to in_ready.
- out_data, out_valid and out_op are driven directly from registers.
- Stall boundary: if out_ready falls with a full pipeline, no data is lost or duplicated. On release, results continue in order.
- Simultaneous flush and out_ready=1: the current output counts as consumed; the pipeline is then emptied.

## Configuration
- GATE_TREE_CNT_EN defined:
  - Adds port result_cnt, which increments on each out_valid && out_ready.
  - Saturates at 16'hFFFF.
  - Reset value 0; cleared by flush, with clear priority over increment.
- Undefined: the port and its counter are absent. Datapath behaviour is identical.

## Structure
- Shared package gate_tree_pkg holds:
  - op_e enum (OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NAND=2'b11)
  - function clog2
  - CNT_W=16
- One sub-module, gate_tree_stage, parametrised by input count and LANES.
  - Contains the pairwise combine, the valid/op/data registers and the stall hold.
  - Instantiated LVL times through a generate loop.
  - Top level owns the NAND output inversion, the handshake and the counter.

## Test plan
Default parameters (N_IN=4, LANES=1) unless stated:
- Exhaustive sweep: in_data=0..15, op AND, out_ready=1, back-to-back.
  - out_data=1 only for 4'hF.
  - Each result appears 2 cycles after its input, 16 results in order.
- Mixed ops back-to-back, 4'b1010 with ops 00, 01, 10, 11 → out_data 0, 1, 0, 1 with out_op matching each.
- Backpressure: hold out_ready=0 for 5 cycles with the pipeline full.
  - in_ready=0 throughout; outputs held stable.
  - On release, all results arrive in order with no loss or duplication.
- Flush with 2 items in flight plus in_valid in the same cycle.
  - Next cycle: out_valid=0, and no outputs follow.
  - result_cnt=0 if GATE_TREE_CNT_EN is defined.
- rst_n pulsed low asynchronously mid-stream.
  - Outputs go to 0/00 immediately.
  - First new input resumes with the normal 2-cycle latency.
- N_IN=16, LANES=8, XOR of operands 8'h01..8'h10, out_ready=1 → out_data=8'h10, 4 cycles after acceptance.
